sha2_compress_engine: RTL

Complete SHA-224/SHA-256 compression engine for 512-bit padded blocks. Contains the working registers a..h, an internal 16-word rolling message schedule, the K constant ROM, a round counter and feed-forward of the chaining value. Supports multi-block messages and runtime SHA-224/256 selection. UNROLL sets rounds per clock. Sits between the padding/block-assembly front end and the digest output interface.

---
 rtl/sha2_pkg.sv | 75 +++++++
 rtl/sha2_round.sv | 20 ++
 rtl/sha2_compress_engine.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/sha2_pkg.sv
// SHA-224/256 shared constants, FSM state type and round functions.
// Imported by sha2_round and sha2_compress_engine.
package sha2_pkg;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [255:0] IV224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  function automatic logic [31:0] rotr(
    input logic [31:0] x,
    input int          n
  );
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] Sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] Sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] Ch(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic [31:0] z
  );
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] Maj(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic [31:0] z
  );
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha2_round.sv
// One combinational SHA-2 round: {a..h} with Kt, Wt -> next {a..h}.
// Word a sits in cur[255:224], h in cur[31:0].
module sha2_round
  import sha2_pkg::*;
(
  input  logic [255:0] cur,
  input  logic [31:0]  k,
  input  logic [31:0]  w,
  output logic [255:0] nxt
);

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] t1, t2;

  assign {a, b, c, d, e, f, g, h} = cur;
  assign t1 = h + Sigma1(e) + Ch(e, f, g) + k + w;
  assign t2 = Sigma0(a) + Maj(a, b, c);
  assign nxt = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha2_compress_engine.sv
// SHA-224/256 block compression engine, UNROLL rounds per clock.
// Define SHA2_ZEROIZE_EN to add the synchronous zeroize_i clear.
module sha2_compress_engine
  import sha2_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid_i,
  output logic         blk_ready_o,
  input  logic [511:0] blk_i,
  input  logic         first_i,
  input  logic         mode_i,
  output logic         digest_valid_o,
  output logic [255:0] digest_o,
`ifdef SHA2_ZEROIZE_EN
  input  logic         zeroize_i,
`endif
  output logic         busy_o
);

  localparam int ROUND_CYCLES = 64 / UNROLL;
  localparam logic [5:0] T_LAST = 6'(UNROLL * (ROUND_CYCLES - 1));

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
    $error("UNROLL must be 1, 2 or 4");
  end

  state_t       state, nstate;
  logic [255:0] wv, hv, dig;
  logic [255:0] rnd_out, hsum, dmask, cv;
  logic [31:0]  w  [16];
  logic [31:0]  wn [16];
  logic [5:0]   t;
  logic         mode, zero, accept;

`ifdef SHA2_ZEROIZE_EN
  assign zero = zeroize_i;
`else
  assign zero = 1'b0;
`endif

  assign accept = (state == IDLE) && blk_valid_i && !zero;
  assign cv = first_i ? (mode_i ? IV224 : IV256) : hv;

  // Schedule words 16..16+UNROLL-1 past the window; later ones reuse earlier.
  for (genvar j = 0; j < UNROLL; j++) begin : g_sch
    logic [31:0] v;
    if (j < 2) begin : g_lo
      assign v = sigma1(w[14 + j]) + w[9 + j]
               + sigma0(w[1 + j]) + w[j];
    end else begin : g_hi
      assign v = sigma1(g_sch[j - 2].v) + w[9 + j]
               + sigma0(w[1 + j]) + w[j];
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_shift
    if (i + UNROLL < 16) begin : g_old
      assign wn[i] = w[i + UNROLL];
    end else begin : g_new
      assign wn[i] = g_sch[i + UNROLL - 16].v;
    end
  end

  for (genvar j = 0; j < UNROLL; j++) begin : g_rnd
    logic [255:0] src, o;
    if (j == 0) begin : g_head
      assign src = wv;
    end else begin : g_link
      assign src = g_rnd[j - 1].o;
    end
    sha2_round u_round (
      .cur (src),
      .k   (K[t + 6'(j)]),
      .w   (w[j]),
      .nxt (o)
    );
  end

  assign rnd_out = g_rnd[UNROLL - 1].o;

  always_comb begin
    hsum = '0;
    for (int i = 0; i < 8; i++)
      hsum[32*i +: 32] = hv[32*i +: 32] + wv[32*i +: 32];
  end

  assign dmask = mode ? {hsum[255:32], 32'h0} : hsum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (accept) nstate = ROUND;
      ROUND:   if (t == T_LAST) nstate = FINAL;
      FINAL:   nstate = IDLE;
      default: nstate = IDLE;
    endcase
    if (zero) nstate = IDLE;
  end

  always_comb begin
    blk_ready_o    = 1'b0;
    busy_o         = 1'b1;
    digest_valid_o = 1'b0;
    digest_o       = dig;
    unique case (state)
      IDLE: begin
        blk_ready_o = rst_n && !zero;
        busy_o      = 1'b0;
      end
      FINAL: begin
        digest_valid_o = !zero;
        if (!zero) digest_o = dmask;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wv   <= '0;
      hv   <= '0;
      dig  <= '0;
      t    <= '0;
      mode <= 1'b0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else if (zero) begin
      wv   <= '0;
      hv   <= '0;
      dig  <= '0;
      t    <= '0;
      mode <= 1'b0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < 16; i++) w[i] <= blk_i[511 - 32*i -: 32];
      wv <= cv;
      hv <= cv;
      t  <= '0;
      if (first_i) mode <= mode_i;
    end else if (state == ROUND) begin
      for (int i = 0; i < 16; i++) w[i] <= wn[i];
      wv <= rnd_out;
      t  <= t + 6'(UNROLL);
    end else if (state == FINAL) begin
      hv  <= hsum;
      dig <= dmask;
    end
  end

endmodule
